buck_sample_tx: RTL
===================

Name: buck_sample_tx

Overview:
Read side of the buck-converter simulator's output bus. The block samples the simulator's v_1 / v_2 integer / v_2 fractional outputs at a fixed decimation rate and queues the samples in a small FIFO. It serialises each sample as a 6-byte framed UART 8N1 stream to the host. It sits between the simulator core and the board's UART pin.

Parameters:
CLK_DIV, 434, clock cycles per UART bit (>= 2)
DECIM, 101, clock cycles between sample captures (>= 2)
FIFO_DEPTH, 8, sample FIFO entries (power of 2, >= 2)

Ports:
clk_i  input  1  system clock, all logic on rising edge
rst_ni  input  1  asynchronous active-low reset
en_i  input  1  capture enable
v_1_i  input  4  simulator v_1 output
v_2i_i  input  16  simulator v_2 integer part
v_2d_i  input  16  simulator v_2 fractional part
tx_o  output  1  UART serial out, idle high
busy_o  output  1  FSM not IDLE or FIFO non-empty
overflow_o  output  1  sticky: a capture was dropped

Behaviour:
- Reset (async assert, sync release): tx_o=1, busy_o=0, overflow_o=0, FIFO empty, decimation counter=0, FSM=IDLE.
- Decimation counter:
  - While en_i=1, counts 0..DECIM-1 and wraps.
  - While en_i=0, it is forced to 0.
  - On the edge where count==DECIM-1 and en_i=1 (capture edge), {v_1_i, v_2i_i, v_2d_i} (36 bits) is written to the FIFO.
- FIFO:
  - A capture into a full FIFO is dropped and sets overflow_o=1. overflow_o clears only on reset.
  - If push and pop occur on the same edge while full, the pop frees a slot and the push is accepted, so overflow_o is not set.
- Frame, bytes in order:
  - 0xA5
  - {4'h0, v_1}
  - v_2i[15:8], v_2i[7:0]
  - v_2d[15:8], v_2d[7:0]
- Byte format: start bit 0, data bits LSB first, stop bit 1. Every bit is held exactly CLK_DIV cycles. One frame is 60*CLK_DIV cycles plus 1 LOAD cycle.
- FSM states: IDLE, LOAD, START, DATA, STOP.
  - IDLE: tx_o=1. If the FIFO is non-empty, pop and go to LOAD.
  - LOAD: latch the popped sample into the frame register, byte index=0, tx_o=1, go to START next cycle.
  - START: tx_o=0 for CLK_DIV cycles, then go to DATA with bit index=0.
  - DATA: tx_o=current byte[bit index] for CLK_DIV cycles per bit. After bit 7, go to STOP.
  - STOP: tx_o=1 for CLK_DIV cycles.
    - If byte index<5: increment it and go to START.
    - Else if the FIFO is non-empty: pop and go to LOAD.
    - Else: go to IDLE.
- Latency, from a capture edge with FSM in IDLE and FIFO empty:
  - FIFO non-empty on the next cycle.
  - The IDLE pop edge moves the FSM to LOAD.
  - tx_o goes low 3 clock edges after the capture edge.
- Frame isolation: the frame register is independent of the FIFO. New captures never corrupt the frame in flight.
- en_i deassert mid-frame: the frame in flight and all queued samples are still transmitted. Only new captures stop.
- busy_o is combinational from FSM state and FIFO empty flag.
- Reset asserted mid-frame: tx_o=1 immediately (asynchronously). Queued samples are discarded. After release, the next transmission starts with a complete frame beginning 0xA5.

Test Plan:
1. CLK_DIV=4, DECIM=300, en_i=1, v_1_i=4'hA, v_2i_i=16'h0001, v_2d_i=16'h8000 -> tx_o falls 3 edges after the first capture. Decoded bytes A5 0A 00 01 80 00. Each bit is exactly 4 cycles wide. busy_o=0 after the stop bit. overflow_o=0.
2. CLK_DIV=4, DECIM=20, FIFO_DEPTH=4, inputs changed after each capture -> capture 1 is popped at once and captures 2-5 fill the FIFO. Capture 6 is dropped and overflow_o=1 stays high. Exactly frames 1-5 are transmitted, carrying the values of captures 1-5.
3. CLK_DIV=4, DECIM=241, en_i=1 for 10 captures -> 10 back-to-back frames, each 241 cycles from one start bit to the next. overflow_o=0. FIFO occupancy never exceeds 1.
4. en_i=0 for 1000 cycles with changing inputs -> tx_o=1, busy_o=0 throughout. After en_i=1, the first capture occurs DECIM-1 edges later.
5. Assert rst_ni=0 during byte 3 of a frame with 2 samples queued -> tx_o=1 and busy_o=0 while in reset. After release with en_i=0, no further output. With en_i=1, the next frame starts with 0xA5 and carries a fresh capture.
6. CLK_DIV=2 (minimum), DECIM=2 -> all bits exactly 2 cycles wide. overflow_o=1 after FIFO_DEPTH+2 captures.

Source files
------------

// File: rtl/buck_sample_tx.sv
// Decimated sampler for the buck-converter simulator outputs: queues {v_1, v_2i, v_2d}
// captures in a small FIFO and streams each one as a 6-byte UART 8N1 frame headed by 0xA5.
module buck_sample_tx #(
    parameter int unsigned CLK_DIV    = 434,
    parameter int unsigned DECIM      = 101,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic [3:0]  v_1_i,
    input  logic [15:0] v_2i_i,
    input  logic [15:0] v_2d_i,
    output logic        tx_o,
    output logic        busy_o,
    output logic        overflow_o
);
    localparam int unsigned SW = 36;
    localparam int unsigned DW = $clog2(DECIM);
    localparam int unsigned BW = $clog2(CLK_DIV);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_t;

    // Decimation counter; a capture fires on its terminal count.
    logic [DW-1:0] dec_q;
    logic          capture;

    assign capture = en_i && (dec_q == DW'(DECIM - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dec_q <= '0;
        end else if (!en_i || capture) begin
            dec_q <= '0;
        end else begin
            dec_q <= dec_q + DW'(1);
        end
    end

    // Sample FIFO with wrap-bit pointers; a pop on the same edge frees the slot for a push.
    logic [SW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic          empty, full, push, pop;
    logic          ovf_q;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign push  = capture && (!full || pop);

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_q[AW-1:0]] <= {v_1_i, v_2i_i, v_2d_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (push) wr_q <= wr_q + PW'(1);
            if (pop)  rd_q <= rd_q + PW'(1);
            if (capture && full && !pop) ovf_q <= 1'b1;
        end
    end

    // Transmit FSM state and frame registers.
    state_t        state_q, state_d;
    logic [BW-1:0] div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic [2:0]    byte_q, byte_d;
    logic [SW-1:0] frame_q, frame_d;
    logic          tx_q, tx_d;
    logic [7:0]    cur_byte;
    logic          last_cyc;

    assign last_cyc = (div_q == BW'(CLK_DIV - 1));

    always_comb begin
        cur_byte = frame_q[7:0];
        case (byte_q)
            3'd0:    cur_byte = SYNC_BYTE;
            3'd1:    cur_byte = {4'h0, frame_q[35:32]};
            3'd2:    cur_byte = frame_q[31:24];
            3'd3:    cur_byte = frame_q[23:16];
            3'd4:    cur_byte = frame_q[15:8];
            default: cur_byte = frame_q[7:0];
        endcase
    end

    // The FIFO head is copied on the pop edge, so a same-edge push into that slot cannot reach the frame.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        frame_d = frame_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    frame_d = mem_q[rd_q[AW-1:0]];
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                byte_d  = '0;
                div_d   = '0;
                state_d = S_START;
            end
            S_START: begin
                tx_d = 1'b0;
                if (last_cyc) begin
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    div_d = div_q + BW'(1);
                end
            end
            S_DATA: begin
                tx_d = cur_byte[bit_q];
                if (last_cyc) begin
                    div_d = '0;
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    div_d = div_q + BW'(1);
                end
            end
            S_STOP: begin
                if (last_cyc) begin
                    div_d = '0;
                    if (byte_q != 3'd5) begin
                        byte_d  = byte_q + 3'd1;
                        state_d = S_START;
                    end else if (!empty) begin
                        pop     = 1'b1;
                        frame_d = mem_q[rd_q[AW-1:0]];
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    div_d = div_q + BW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            frame_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            frame_q <= frame_d;
            tx_q    <= tx_d;
        end
    end

    assign tx_o       = tx_q;
    assign busy_o     = (state_q != S_IDLE) || !empty;
    assign overflow_o = ovf_q;

endmodule
